audio_mode_ctrl: RTL

- Mode sequencer for the audio codec record/play datapath; runs on the 50 MHz system clock.
- Turns debounced key pulses into the codec's `record`, `stop`, `fast` and `rate` controls.
- Holds `stop` long enough for the slower AUD_BCLK domain to sample it.
- Tracks recorded length and playback position from synchronised LRCK edges, and ends playback or recording automatically at the boundaries.

---
 rtl/audio_mode_ctrl_if.sv | 32 +++
 rtl/audio_mode_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/audio_mode_ctrl_if.sv
// Key, codec-clock and codec-control bundle for audio_mode_ctrl.
// The master side drives the keys and LR clocks; the slave side is the sequencer.
interface audio_mode_ctrl_if #(
  parameter int ADDR_W = 18
);
  logic              key_record;
  logic              key_play;
  logic              key_stop;
  logic              key_faster;
  logic              key_slower;
  logic              AUD_ADCLRCK;
  logic              AUD_DACLRCK;
  logic              record;
  logic              stop;
  logic              fast;
  logic [2:0]        rate;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] rec_len;
  logic [ADDR_W-1:0] play_pos;

  modport master (
    output key_record, key_play, key_stop, key_faster, key_slower,
    output AUD_ADCLRCK, AUD_DACLRCK,
    input  record, stop, fast, rate, mode, rec_len, play_pos
  );

  modport slave (
    input  key_record, key_play, key_stop, key_faster, key_slower,
    input  AUD_ADCLRCK, AUD_DACLRCK,
    output record, stop, fast, rate, mode, rec_len, play_pos
  );
endinterface

// File: rtl/audio_mode_ctrl.sv
// audio_mode_ctrl: turns key pulses into codec record/stop/fast/rate controls and tracks frames.
// Optional macro LOOP_PLAY_EN: playback auto-end restarts from frame 0 instead of returning to IDLE.
module audio_mode_ctrl #(
  parameter int STOP_HOLD = 64,
  parameter int ADDR_W    = 18
) (
  input logic              clk,
  input logic              rst,
  audio_mode_ctrl_if.slave bus
);

  localparam int                HOLD_W    = $clog2(STOP_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STOP_HOLD - 1);
  localparam int                SUM_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLR    = 2'd1,
    RECORD = 2'd2,
    PLAY   = 2'd3
  } state_t;

  state_t            state_q;
  state_t            target_q;
  state_t            clrExit_d;
  logic [HOLD_W-1:0] holdCnt_q;
  logic [ADDR_W-1:0] recLen_q;
  logic [ADDR_W-1:0] playPos_q;
  logic              stop_q;
  logic              record_q;
  logic [2:0]        speed_q;
  logic [2:0]        speed_d;
  logic              fast_q;
  logic [1:0]        adcSync_q;
  logic [1:0]        dacSync_q;
  logic              adcHist_q;
  logic              dacHist_q;
  logic              adcRise;
  logic              dacFall;
  logic [3:0]        step;
  logic [SUM_W-1:0]  playSum_d;
  logic              playEnd;
  logic              recLast;

  // Two-flop synchronisers plus a history flop give clean single-cycle LRCK edge events.
  always_ff @(posedge clk) begin
    if (rst) begin
      adcSync_q <= '0;
      dacSync_q <= '0;
      adcHist_q <= 1'b0;
      dacHist_q <= 1'b0;
    end else begin
      adcSync_q <= {adcSync_q[0], bus.AUD_ADCLRCK};
      dacSync_q <= {dacSync_q[0], bus.AUD_DACLRCK};
      adcHist_q <= adcSync_q[1];
      dacHist_q <= dacSync_q[1];
    end
  end

  assign adcRise = adcSync_q[1] & ~adcHist_q;
  assign dacFall = ~dacSync_q[1] & dacHist_q;

  always_comb begin
    speed_d = speed_q;
    if (bus.key_faster && !bus.key_slower && speed_q != 3'd7) begin
      speed_d = speed_q + 3'd1;
    end else if (bus.key_slower && !bus.key_faster && speed_q != 3'd0) begin
      speed_d = speed_q - 3'd1;
    end
    clrExit_d = bus.key_stop ? IDLE : target_q;
    // Step mirrors the codec's fast-play address increment.
    step = (!fast_q || speed_q == 3'd0) ? 4'd1 : (4'd8 + {1'b0, speed_q});
    playSum_d = {1'b0, playPos_q} + SUM_W'(step);
    playEnd   = playSum_d >= {1'b0, recLen_q};
    recLast   = recLen_q >= (ADDR_MAX - ADDR_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      target_q  <= IDLE;
      holdCnt_q <= '0;
      recLen_q  <= '0;
      playPos_q <= '0;
      stop_q    <= 1'b1;
      record_q  <= 1'b0;
      speed_q   <= 3'd0;
      fast_q    <= 1'b0;
    end else begin
      speed_q <= speed_d;
      fast_q  <= (speed_d != 3'd0);
      unique case (state_q)
        IDLE: begin
          if (bus.key_record) begin
            state_q   <= CLR;
            target_q  <= RECORD;
            holdCnt_q <= '0;
          end else if (bus.key_play && recLen_q != '0) begin
            state_q   <= CLR;
            target_q  <= PLAY;
            holdCnt_q <= '0;
          end
        end
        CLR: begin
          target_q <= clrExit_d;
          if (holdCnt_q == HOLD_LAST) begin
            holdCnt_q <= '0;
            state_q   <= clrExit_d;
            stop_q    <= (clrExit_d == IDLE);
            record_q  <= (clrExit_d == RECORD);
            if (clrExit_d == RECORD) recLen_q <= '0;
            if (clrExit_d == PLAY) playPos_q <= '0;
          end else begin
            holdCnt_q <= holdCnt_q + HOLD_W'(1);
          end
        end
        RECORD: begin
          if (bus.key_stop) begin
            state_q  <= IDLE;
            stop_q   <= 1'b1;
            record_q <= 1'b0;
          end else if (adcRise) begin
            if (recLast) begin
              recLen_q <= ADDR_MAX;
              state_q  <= IDLE;
              stop_q   <= 1'b1;
              record_q <= 1'b0;
            end else begin
              recLen_q <= recLen_q + ADDR_W'(1);
            end
          end
        end
        PLAY: begin
          if (bus.key_stop) begin
            state_q <= IDLE;
            stop_q  <= 1'b1;
          end else if (dacFall) begin
            if (playEnd) begin
              playPos_q <= recLen_q;
              stop_q    <= 1'b1;
`ifdef LOOP_PLAY_EN
              state_q   <= CLR;
              target_q  <= PLAY;
              holdCnt_q <= '0;
`else
              state_q   <= IDLE;
`endif
            end else begin
              playPos_q <= playSum_d[ADDR_W-1:0];
            end
          end
        end
      endcase
    end
  end

  assign bus.mode     = state_q;
  assign bus.stop     = stop_q;
  assign bus.record   = record_q;
  assign bus.fast     = fast_q;
  assign bus.rate     = speed_q;
  assign bus.rec_len  = recLen_q;
  assign bus.play_pos = playPos_q;

endmodule
